// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester-side and FIFO-write-side signals of the shared write-port arbiter
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 1024,
   parameter int LEN_WIDTH  = 4,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
);
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*LEN_WIDTH-1:0] req_len;
   logic [NUM_REQ*WIDTH-1:0]     req_data;
   logic [NUM_REQ-1:0]           req_ready;
   logic                         fifo_wr_en;
   logic [WIDTH-1:0]             fifo_wr_data;
   logic                         fifo_wr_full;
   logic [ADDR_WIDTH:0]          fifo_count;
   logic [NUM_REQ-1:0]           gnt;
   logic                         busy;
   logic                         err_overflow;
   modport master (
      output req_valid, req_len, req_data, fifo_wr_full, fifo_count,
      input  req_ready, fifo_wr_en, fifo_wr_data, gnt, busy, err_overflow
   );
   modport slave (
      input  req_valid, req_len, req_data, fifo_wr_full, fifo_count,
      output req_ready, fifo_wr_en, fifo_wr_data, gnt, busy, err_overflow
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-atomic arbiter sharing one FIFO write port
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int LEN_WIDTH  = 4
) (
   input logic               clk,
   input logic               rst,
   fifo_wr_arbiter_if.slave  wr_if
);
   localparam int OW = $clog2(NUM_REQ);
   localparam int RW = LEN_WIDTH + 1;
   localparam int CW = ADDR_WIDTH + 1;
   typedef enum logic [1:0] {IDLE, WAIT_SPACE, BURST} state_t;
   state_t        state_q, state_d;
   logic [OW-1:0] rr_q, rr_d, own_q, own_d, win;
   logic [RW-1:0] rem_q, rem_d, need;
   logic [CW-1:0] free;
   logic          err_q, err_d, any, fits, try_wr, wr;
   function automatic logic [OW-1:0] wrap(input int k);
      return OW'(k >= NUM_REQ ? k - NUM_REQ : k);
   endfunction
   // Scan downward so the requester closest above rr_q is the last, winning assignment
   always_comb begin
      win = rr_q;
      any = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (wr_if.req_valid[wrap(int'(rr_q) + i)]) begin
            win = wrap(int'(rr_q) + i);
            any = 1'b1;
         end
      end
   end
   assign free   = CW'(DEPTH) - wr_if.fifo_count;
   assign need   = state_q == IDLE ? RW'(wr_if.req_len[win*LEN_WIDTH +: LEN_WIDTH]) + RW'(1) : rem_q;
   assign fits   = free >= CW'(need);
   assign try_wr = state_q == BURST && wr_if.req_valid[own_q];
   assign wr     = try_wr && !wr_if.fifo_wr_full;
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      own_d   = own_q;
      rem_d   = rem_q;
      err_d   = err_q | (try_wr & wr_if.fifo_wr_full);
      if (state_q == IDLE && any) begin
         own_d   = win;
         rem_d   = need;
         state_d = fits ? BURST : WAIT_SPACE;
      end
      if (state_q == WAIT_SPACE && fits) state_d = BURST;
      if (wr) begin
         rem_d = rem_q - RW'(1);
         if (rem_q == RW'(1)) begin
            state_d = IDLE;
            rr_d    = own_q == OW'(NUM_REQ - 1) ? '0 : own_q + OW'(1);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         own_q   <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         own_q   <= own_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
      end
   end
   assign wr_if.gnt          = state_q == IDLE ? '0 : {{(NUM_REQ-1){1'b0}}, 1'b1} << own_q;
   assign wr_if.req_ready    = state_q == BURST ? wr_if.gnt : '0;
   assign wr_if.fifo_wr_en   = wr;
   assign wr_if.fifo_wr_data = state_q == BURST ? wr_if.req_data[own_q*WIDTH +: WIDTH] : '0;
   assign wr_if.busy         = state_q != IDLE;
   assign wr_if.err_overflow = err_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table vectors plus directed multi-cycle sequences for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int D  = 1024;
   localparam int LW = 4;
   localparam int CW = $clog2(D) + 1;
   typedef struct packed {
      logic [N-1:0]    v;
      logic [N*LW-1:0] len;
      logic [N*W-1:0]  data;
      logic            wr;
      logic [W-1:0]    wd;
      logic [N-1:0]    g;
      logic [N-1:0]    rd;
      logic            b;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   int cnt = 0;
   int pend = 0;
   bit manual = 1'b1;
   logic [W-1:0] log_q[$];
   int left[N];
   int idx[N];
   logic [W-1:0] base[N];
   logic [LW-1:0] plen[N];
   bit hold[N];
   vec_t vec[9];
   always #5 clk = ~clk;
   fifo_wr_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D), .LEN_WIDTH(LW)) bus();
   fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst), .wr_if(bus)
   );
   assign bus.fifo_count = CW'(cnt);
   function automatic logic [26:0] outs();
      return {bus.fifo_wr_en, bus.fifo_wr_data, bus.gnt, bus.req_ready, bus.busy, bus.err_overflow};
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask
   task automatic chk_seq(input string name, input int off, input logic [W-1:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         if (off + i < log_q.size()) chk($sformatf("%s%0d", name, i), 64'(log_q[off+i]), 64'(b + W'(i)));
         else chk($sformatf("%s%0d_missing", name, i), 64'hDEAD_0000_0000, 64'(b + W'(i)));
      end
   endtask
   task automatic drive();
      for (int r = 0; r < N; r++) begin
         bus.req_valid[r] = left[r] > 0 && !hold[r];
         bus.req_len[r*LW +: LW] = plen[r];
         bus.req_data[r*W +: W] = base[r] + W'(idx[r]);
      end
   endtask
   // Requester model: a word is consumed only when it is actually written
   task automatic cyc();
      @(negedge clk);
      if (bus.fifo_wr_en) begin
         log_q.push_back(bus.fifo_wr_data);
         pend++;
         for (int r = 0; r < N; r++) begin
            if (bus.gnt[r] && left[r] > 0) begin
               idx[r]++;
               left[r]--;
            end
         end
      end
      @(posedge clk);
      #1;
      cnt += pend;
      pend = 0;
      if (!manual) drive();
      #1;
   endtask
   task automatic start(input int r, input int len, input logic [W-1:0] b);
      plen[r] = LW'(len);
      left[r] = len + 1;
      idx[r]  = 0;
      base[r] = b;
   endtask
   function automatic bit pending();
      for (int r = 0; r < N; r++) if (left[r] > 0) return 1'b1;
      return 1'b0;
   endfunction
   task automatic run(input string name, input int max);
      int n = 0;
      while (n < max && (pending() || bus.busy)) begin
         cyc();
         n++;
      end
      chk({name, "_timeout"}, 64'(pending() || bus.busy), 64'h0);
   endtask
   task automatic do_reset();
      rst = 1'b1;
      for (int r = 0; r < N; r++) begin
         left[r] = 0;
         hold[r] = 1'b0;
      end
      drive();
      cyc();
      rst = 1'b0;
      cnt = 0;
      log_q.delete();
   endtask
   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      vec[0] = '{4'h1, 16'h0002, 64'h00A1,      1'b0, 16'h0000, 4'h0, 4'h0, 1'b0};
      vec[1] = '{4'h1, 16'h0002, 64'h00A1,      1'b1, 16'h00A1, 4'h1, 4'h1, 1'b1};
      vec[2] = '{4'h1, 16'h0002, 64'h00A2,      1'b1, 16'h00A2, 4'h1, 4'h1, 1'b1};
      vec[3] = '{4'h1, 16'h0002, 64'h00A3,      1'b1, 16'h00A3, 4'h1, 4'h1, 1'b1};
      vec[4] = '{4'h3, 16'h0000, 64'h00B1_00B0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0};
      vec[5] = '{4'h3, 16'h0000, 64'h00B1_00B0, 1'b1, 16'h00B1, 4'h2, 4'h2, 1'b1};
      vec[6] = '{4'h1, 16'h0000, 64'h00B0,      1'b0, 16'h0000, 4'h0, 4'h0, 1'b0};
      vec[7] = '{4'h1, 16'h0000, 64'h00B0,      1'b1, 16'h00B0, 4'h1, 4'h1, 1'b1};
      vec[8] = '{4'h0, 16'h0000, 64'h0,         1'b0, 16'h0000, 4'h0, 4'h0, 1'b0};
      bus.req_valid = '0;
      bus.req_len = '0;
      bus.req_data = '0;
      bus.fifo_wr_full = 1'b0;
      for (int r = 0; r < N; r++) begin
         left[r] = 0;
         idx[r] = 0;
         base[r] = '0;
         plen[r] = '0;
         hold[r] = 1'b0;
      end
      bus.req_valid = 4'hF;
      cyc();
      cyc();
      chk("reset_outs", 64'(outs()), 64'h0);
      bus.req_valid = '0;
      rst = 1'b0;
      // Single packet then round-robin pointer follow-up, cycle by cycle
      for (int i = 0; i < 9; i++) begin
         bus.req_valid = vec[i].v;
         bus.req_len = vec[i].len;
         bus.req_data = vec[i].data;
         #1;
         chk($sformatf("vec%0d", i), 64'(outs()), 64'({vec[i].wr, vec[i].wd, vec[i].g, vec[i].rd, vec[i].b, 1'b0}));
         cyc();
      end
      manual = 1'b0;
      do_reset();
      for (int r = 0; r < N; r++) start(r, 0, W'(16'hC000 + r * 256));
      drive();
      run("rr", 20);
      chk("rr_n", 64'(log_q.size()), 64'd4);
      for (int r = 0; r < N; r++) chk_seq($sformatf("rr_ord%0d_", r), r, W'(16'hC000 + r * 256), 1);
      log_q.delete();
      start(2, 0, 16'hD200);
      start(0, 0, 16'hD000);
      drive();
      run("rr2", 20);
      chk("rr2_n", 64'(log_q.size()), 64'd2);
      chk_seq("rr2_a", 0, 16'hD000, 1);
      chk_seq("rr2_b", 1, 16'hD200, 1);
      do_reset();
      cnt = 1020;
      start(1, 7, 16'hE000);
      drive();
      #1;
      cyc();
      chk("wait_a", 64'(outs()), 64'({1'b0, 16'h0, 4'h2, 4'h0, 1'b1, 1'b0}));
      repeat (3) cyc();
      chk("wait_b", 64'(outs()), 64'({1'b0, 16'h0, 4'h2, 4'h0, 1'b1, 1'b0}));
      cnt = 1016;
      run("space", 30);
      chk("space_n", 64'(log_q.size()), 64'd8);
      chk_seq("space_d", 0, 16'hE000, 8);
      chk("space_err", 64'(bus.err_overflow), 64'h0);
      do_reset();
      start(3, 3, 16'hF300);
      drive();
      #1;
      cyc();
      cyc();
      hold[3] = 1'b1;
      start(2, 0, 16'hF200);
      drive();
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bubble%0d", k), 64'({bus.fifo_wr_en, bus.gnt, bus.req_ready}), 64'({1'b0, 4'h8, 4'h8}));
         cyc();
      end
      hold[3] = 1'b0;
      drive();
      #1;
      run("bubble", 20);
      chk("bubble_n", 64'(log_q.size()), 64'd5);
      chk_seq("bubble_d", 0, 16'hF300, 4);
      chk_seq("bubble_r2", 4, 16'hF200, 1);
      do_reset();
      start(1, 4, 16'hA500);
      drive();
      #1;
      repeat (3) cyc();
      chk("midrst_n", 64'(log_q.size()), 64'd2);
      rst = 1'b1;
      cyc();
      chk("midrst_outs", 64'(outs()), 64'h0);
      rst = 1'b0;
      left[1] = 0;
      log_q.delete();
      start(3, 0, 16'h3000);
      start(0, 0, 16'h0001);
      drive();
      #1;
      run("midrst", 20);
      chk("midrst_n2", 64'(log_q.size()), 64'd2);
      chk_seq("midrst_a", 0, 16'h0001, 1);
      chk_seq("midrst_b", 1, 16'h3000, 1);
      do_reset();
      cnt = D - 16;
      start(2, 15, 16'hB200);
      drive();
      #1;
      cyc();
      chk("max_grant", 64'(outs()), 64'({1'b1, 16'hB200, 4'h4, 4'h4, 1'b1, 1'b0}));
      repeat (4) cyc();
      bus.fifo_wr_full = 1'b1;
      #1;
      chk("full_sup", 64'({bus.fifo_wr_en, bus.gnt, bus.busy}), 64'({1'b0, 4'h4, 1'b1}));
      cyc();
      bus.fifo_wr_full = 1'b0;
      #1;
      chk("err_set", 64'(bus.err_overflow), 64'h1);
      run("maxlen", 40);
      chk("max_n", 64'(log_q.size()), 64'd16);
      chk_seq("max_d", 0, 16'hB200, 16);
      chk("err_sticky", 64'(bus.err_overflow), 64'h1);
      do_reset();
      chk("err_clr", 64'(bus.err_overflow), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
